// File: rtl/mips_register_file_if.sv
// Register-file access bundle: write-back port, two operand read ports and a debug read port.
interface mips_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [ADDR_WIDTH-1:0] ReadReg1;
  logic [ADDR_WIDTH-1:0] ReadReg2;
  logic [ADDR_WIDTH-1:0] DebugReg;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;
  logic [DATA_WIDTH-1:0] DebugData;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DebugReg,
    input  ReadData1, ReadData2, DebugData
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DebugReg,
    output ReadData1, ReadData2, DebugData
  );
endinterface

// File: rtl/mips_register_file.sv
// 32-entry MIPS GPR file: r0 hardwired to zero, same-cycle write-through on the two
// operand ports, raw stored contents on the debug port, async active-high clear.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                clk,
  input logic                reset,
  mips_register_file_if.slave rf
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NUM_RD = 2;

  logic [DATA_WIDTH-1:0] ent [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (i == 0) begin : g_zero
      assign ent[i] = '0;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge clk or posedge reset)
        if (reset)
          q <= '0;
        else if (rf.RegWrite && rf.WriteReg == ADDR_WIDTH'(i))
          q <= rf.WriteData;
      assign ent[i] = q;
    end
  end

  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_idx;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_dat;

  assign rd_idx = {rf.ReadReg2, rf.ReadReg1};

  // Bypass is gated by reset so the read ports track the cleared array while reset is high.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_dat[p] = (rd_idx[p] == '0) ? '0 :
                       (!reset && rf.RegWrite && rd_idx[p] == rf.WriteReg) ? rf.WriteData :
                       ent[rd_idx[p]];
  end

  assign rf.ReadData1 = rd_dat[0];
  assign rf.ReadData2 = rd_dat[1];
  assign rf.DebugData = ent[rf.DebugReg];
endmodule

// File: tb/tb_mips_register_file.sv
// Directed plus randomized bench for mips_register_file against an array reference model.
module tb_mips_register_file;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] model [32];

  mips_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf)
  );

  always #50 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    rf.RegWrite = we; rf.WriteReg = wr; rf.WriteData = wd;
    rf.ReadReg1 = r1; rf.ReadReg2 = r2; rf.DebugReg = dbg;
    #1;
  endtask

  // Expected operand-port value from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (!reset && rf.RegWrite && idx == rf.WriteReg) return rf.WriteData;
    return model[idx];
  endfunction

  function automatic logic [31:0] exp_dbg(input logic [4:0] idx);
    return (idx == 0) ? 32'h0 : model[idx];
  endfunction

  // One rising edge; the model commits what the design should commit, then settle off-edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (rf.RegWrite && rf.WriteReg != 0) begin
      model[rf.WriteReg] = rf.WriteData;
    end
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_rd1"}, rf.ReadData1, exp_rd(rf.ReadReg1));
    chk({tag, "_rd2"}, rf.ReadData2, exp_rd(rf.ReadReg2));
    chk({tag, "_dbg"}, rf.DebugData, exp_dbg(rf.DebugReg));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd17, 5'd31);
    chk_all("reset_state");
    reset = 1'b0;

    // 1: preload every entry, then assert reset between edges
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h0101_0101 * i + 32'h5A00_0000, 5'd0, 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd30, 5'd12);
    chk_all("preload");
    drive(1'b1, 5'd5, 32'hCAFE_F00D, 5'd5, 5'd5, 5'd5);
    #10;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      rf.DebugReg = 5'(i);
      #1;
      chk($sformatf("async_clr_dbg%0d", i), rf.DebugData, 32'h0);
    end
    chk("reset_rd1", rf.ReadData1, 32'h0);
    chk("reset_rd2", rf.ReadData2, 32'h0);
    tick();
    reset = 1'b0;

    // 2: basic write/read
    drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0); tick();
    drive(1'b1, 5'd31, 32'h0000_0005, 5'd0, 5'd0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd31, 5'd8);
    chk("basic_rd1", rf.ReadData1, 32'hDEAD_BEEF);
    chk("basic_rd2", rf.ReadData2, 32'h0000_0005);
    chk("basic_dbg", rf.DebugData, 32'hDEAD_BEEF);

    // 3: register zero
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    chk("r0_pre_rd1", rf.ReadData1, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("r0_post_rd1", rf.ReadData1, 32'h0);
    chk("r0_post_dbg", rf.DebugData, 32'h0);

    // 4: bypass
    drive(1'b1, 5'd9, 32'h1111_1111, 5'd0, 5'd0, 5'd0); tick();
    drive(1'b1, 5'd9, 32'h2222_2222, 5'd9, 5'd9, 5'd9);
    chk("byp_pre_rd1", rf.ReadData1, 32'h2222_2222);
    chk("byp_pre_rd2", rf.ReadData2, 32'h2222_2222);
    chk("byp_pre_dbg", rf.DebugData, 32'h1111_1111);
    tick();
    drive(1'b0, 5'd9, 32'h2222_2222, 5'd9, 5'd9, 5'd9);
    chk("byp_post_rd1", rf.ReadData1, 32'h2222_2222);
    chk("byp_post_rd2", rf.ReadData2, 32'h2222_2222);
    chk("byp_post_dbg", rf.DebugData, 32'h2222_2222);

    // 5: write disable
    drive(1'b0, 5'd9, 32'h3333_3333, 5'd9, 5'd0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wdis_rd1_%0d", i), rf.ReadData1, 32'h2222_2222);
    end

    // 6: reset rising on the same edge as a write
    drive(1'b1, 5'd4, 32'hAAAA_AAAA, 5'd4, 5'd0, 5'd4);
    @(posedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 5'd4);
    chk("coll_rd1", rf.ReadData1, 32'h0);
    chk("coll_dbg", rf.DebugData, 32'h0);
    drive(1'b1, 5'd4, 32'h0000_0001, 5'd4, 5'd0, 5'd4);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 5'd4);
    chk("coll_wr_rd1", rf.ReadData1, 32'h0000_0001);
    chk("coll_wr_dbg", rf.DebugData, 32'h0000_0001);

    // randomized traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom,
            ($urandom_range(0, 3) == 0) ? rf.WriteReg : 5'($urandom),
            5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        rf.ReadReg1 = rf.WriteReg;
        rf.ReadReg2 = rf.WriteReg;
        #1;
      end
      chk_all("rand");
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        chk_all("rand_rst");
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
